uart_rx: RTL and testbench
==========================

# uart_rx

Serial receive counterpart to the team's UART transmitter: recovers 8N1 frames (start bit, 8 data bits LSB first, 1 stop bit) from an idle-high line and presents each byte on a one-entry valid/ready output buffer. It sits between the board RX pin and any byte consumer (FIFO, command parser). Frame errors and overruns are reported as single-cycle pulses. An optional compile-time even-parity bit extends the frame to 8E1.

## Interface
- `CLKFREQ`, default 100_000_000: system clock frequency in Hz.
- `BAUDRATE`, default 115200: line bit rate.
- `BIT_CYCLES`, derived, CLKFREQ/BAUDRATE (integer division; 868 at defaults): clocks per bit. Must be ≥ 4.
- `HALF_CYCLES`, derived, BIT_CYCLES/2: clocks from start-bit edge to mid-bit.
- `clk`: input, 1 bit. Single clock; all logic is on the rising edge.
- `reset`: input, 1 bit. Asynchronous, active-low.
- `uartRxBit`: input, 1 bit. Asynchronous serial line, idle high.
- `rxReady`: input, 1 bit. Consumer accepts the byte on any edge where `rxValid && rxReady`.
- `rxByte`: output, 8 bits. Received byte. Stable while `rxValid` is 1.
- `rxValid`: output, 1 bit. Buffer holds an unconsumed byte.
- `frameErr`: output, 1 bit. One-cycle pulse when the stop bit is sampled low.
- `parityErr`: output, 1 bit. One-cycle pulse on a parity mismatch. Tied 0 when parity is compiled out.
- `overrun`: output, 1 bit. One-cycle pulse when a good byte is dropped because the buffer is full.

## Operation
- `uartRxBit` passes through a 2-flop synchronizer. All logic below uses the synchronized signal `rxS`.
- The bit counter `cnt` is wide enough for BIT_CYCLES-1. The bit index counts 0..7.
- State machine states: IDLE, START, DATA, PARITY (present only with the macro), STOP, WAIT_HIGH.
- IDLE: when `rxS` is 0, clear `cnt` and go to START.
- START: at `cnt == HALF_CYCLES-1`, sample `rxS`.
  - If 1: false start; return to IDLE with no outputs.
  - If 0: clear `cnt` and go to DATA with index 0.
- DATA: at `cnt == BIT_CYCLES-1`, shift `rxS` into `shiftReg[index]` (LSB first) and clear `cnt`.
  - After index 7, go to PARITY if compiled in, otherwise STOP.
- PARITY: at `cnt == BIT_CYCLES-1`, capture the parity bit and go to STOP.
- STOP: at `cnt == BIT_CYCLES-1`, sample the stop bit.
  - Stop bit 1 and parity OK: deliver the byte (rules below), then go to IDLE.
  - Stop bit 0: pulse `frameErr`, discard the byte, go to WAIT_HIGH.
  - Stop bit 1 but parity bad: pulse `parityErr`, discard the byte, go to IDLE.
  - Framing takes priority: if both stop and parity are bad, only `frameErr` pulses.
- WAIT_HIGH: stay until `rxS` is 1, then go to IDLE. This keeps a break condition or stuck-low line from producing repeated frames.
- Byte delivery:
  - Buffer empty, or being consumed on the same edge (`rxValid && rxReady`): load `rxByte` and set `rxValid` to 1.
  - Otherwise: drop the new byte, keep the old one, and pulse `overrun`.
- Consume: on an edge with `rxValid && rxReady` and no simultaneous load, clear `rxValid`. `rxByte` holds its last value.
- `rxReady` while `rxValid` is 0 has no effect.

## Timing
- Reset values: `rxByte` 8'h00; `rxValid`, `frameErr`, `parityErr`, `overrun` all 0; both synchronizer flops 1; state IDLE; `cnt` 0.
- Reset asserted mid-frame aborts the frame immediately. After release the block waits in IDLE for the next falling edge; a partial frame is never delivered.
- Edge E0 is the first clock edge where the first synchronizer flop captures 0.
  - IDLE sees `rxS == 0` at edge E0+1 and enters START at edge E0+2 (`cnt` = 0).
  - The start bit is sampled at edge E0+1+HALF_CYCLES.
  - Data bit k is sampled at edge E0+1+HALF_CYCLES+(k+1)·BIT_CYCLES.
  - The stop bit is sampled at edge E0+1+HALF_CYCLES+9·BIT_CYCLES, or +10·BIT_CYCLES with parity.
  - `rxValid`, `frameErr`, `parityErr` and `overrun` update on that same edge (registered outputs, zero extra latency).
- Back-to-back frames are supported: after a good stop sample, IDLE can detect the next start edge on the following cycle.
- Tolerated baud mismatch is ±(HALF_CYCLES-1)/(10·BIT_CYCLES), about ±5%.

## Configuration
- `UART_RX_PARITY_EN` defined:
  - PARITY state is compiled in and the frame is 8E1.
  - Parity is good when the XOR of the 8 data bits and the parity bit is 0.
  - `parityErr` is driven.
- `UART_RX_PARITY_EN` undefined:
  - Frame is 8N1 and the PARITY state does not exist.
  - `parityErr` is constant 0.
  - Stop is sampled one bit earlier, per Timing.

## Test plan
All scenarios use CLKFREQ=1_000_000 and BAUDRATE=100_000, so BIT_CYCLES=10 and HALF_CYCLES=5.
- Single byte: send 8N1 frame 0xA5 with `rxReady` held at 0. Required: `rxValid` rises at edge E0+96, `rxByte` = 0xA5, it holds, and it clears one edge after `rxReady` pulses.
- Glitch: drive `uartRxBit` low for 3 clocks, then high. Required: no `rxValid` and no error pulses; state back in IDLE.
- Framing error: send 0x3C with the stop bit forced to 0 and the line held low for 50 further clocks. Required: one `frameErr` pulse, `rxValid` stays 0, and no new frame starts until the line has been high.
- Overrun: send 0x11 then 0x22 back-to-back with `rxReady` at 0. Required: `rxByte` = 0x11 and one `overrun` pulse at the second stop sample. Repeat with `rxReady` held at 1: both bytes are delivered and no `overrun`.
- Reset: assert `reset` during data bit 4 of 0xFF, release, then send 0x5A. Required: all outputs read their reset values during reset, and the only delivered byte is 0x5A.
- Parity (macro defined): send 0x07 with parity bit 1. Required: `rxByte` = 0x07. Send 0x07 with parity bit 0. Required: one `parityErr` pulse and no `rxValid`.

Source files
------------

// File: rtl/uart_rx.sv
// uart_rx: recovers 8N1 frames from an idle-high serial line into a one-entry valid/ready buffer.
// Define UART_RX_PARITY_EN to receive 8E1 frames (even parity) and drive parityErr.
module uart_rx #(
    parameter int CLKFREQ  = 100_000_000,
    parameter int BAUDRATE = 115200
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       uartRxBit,
    input  logic       rxReady,
    output logic [7:0] rxByte,
    output logic       rxValid,
    output logic       frameErr,
    output logic       parityErr,
    output logic       overrun
);
    localparam int BIT_CYCLES  = CLKFREQ / BAUDRATE;
    localparam int HALF_CYCLES = BIT_CYCLES / 2;
    localparam int CNT_W       = $clog2(BIT_CYCLES);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_CYCLES - 1);
    // START is entered one edge after rxS falls; that edge already counts toward the half bit.
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_CYCLES - 2);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {
        IDLE = 3'd0, START = 3'd1, DATA = 3'd2, PARITY = 3'd3, STOP = 3'd4, WAIT_HIGH = 3'd5
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE = 3'd0, START = 3'd1, DATA = 3'd2, STOP = 3'd4, WAIT_HIGH = 3'd5
    } state_t;
`endif

    state_t           state_r, state_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic [2:0]       idx_r, idx_s;
    logic [7:0]       shift_r, shift_s;
    logic             sync1_r, rx_sync_r;
    logic             deliver_s, frame_s, perr_s, par_bad_s;
    logic [7:0]       rx_byte_r;
    logic             rx_valid_r, frame_err_r, parity_err_r, overrun_r;

`ifdef UART_RX_PARITY_EN
    logic par_r, par_s;

    function automatic logic parity_bad(input logic [7:0] data, input logic par);
        parity_bad = ^{data, par};
    endfunction

    assign par_bad_s = parity_bad(shift_r, par_r);
`else
    assign par_bad_s = 1'b0;
`endif

    // Two-flop synchronizer for the asynchronous line
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_r   <= 1'b1;
            rx_sync_r <= 1'b1;
        end else begin
            sync1_r   <= uartRxBit;
            rx_sync_r <= sync1_r;
        end
    end

    // Frame state, bit timer, bit index and shift register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
            cnt_r   <= '0;
            idx_r   <= 3'd0;
            shift_r <= 8'h00;
`ifdef UART_RX_PARITY_EN
            par_r   <= 1'b0;
`endif
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            idx_r   <= idx_s;
            shift_r <= shift_s;
`ifdef UART_RX_PARITY_EN
            par_r   <= par_s;
`endif
        end
    end

    // Next-state logic and per-frame result events
    always_comb begin
        state_s   = state_r;
        cnt_s     = cnt_r + CNT_W'(1);
        idx_s     = idx_r;
        shift_s   = shift_r;
        deliver_s = 1'b0;
        frame_s   = 1'b0;
        perr_s    = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_s     = par_r;
`endif
        case (state_r)
            IDLE: begin
                cnt_s = '0;
                if (!rx_sync_r) state_s = START;
                else            state_s = IDLE;
            end
            START: begin
                if (cnt_r == HALF_LAST) begin
                    cnt_s = '0;
                    idx_s = 3'd0;
                    if (rx_sync_r) state_s = IDLE;
                    else           state_s = DATA;
                end else begin
                    state_s = START;
                end
            end
            DATA: begin
                if (cnt_r == BIT_LAST) begin
                    cnt_s          = '0;
                    shift_s[idx_r] = rx_sync_r;
                    idx_s          = idx_r + 3'd1;
`ifdef UART_RX_PARITY_EN
                    if (idx_r == 3'd7) state_s = PARITY;
                    else               state_s = DATA;
`else
                    if (idx_r == 3'd7) state_s = STOP;
                    else               state_s = DATA;
`endif
                end else begin
                    state_s = DATA;
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (cnt_r == BIT_LAST) begin
                    cnt_s   = '0;
                    par_s   = rx_sync_r;
                    state_s = STOP;
                end else begin
                    state_s = PARITY;
                end
            end
`endif
            STOP: begin
                if (cnt_r == BIT_LAST) begin
                    cnt_s = '0;
                    if (!rx_sync_r) begin
                        frame_s = 1'b1;
                        state_s = WAIT_HIGH;
                    end else if (par_bad_s) begin
                        perr_s  = 1'b1;
                        state_s = IDLE;
                    end else begin
                        deliver_s = 1'b1;
                        state_s   = IDLE;
                    end
                end else begin
                    state_s = STOP;
                end
            end
            WAIT_HIGH: begin
                cnt_s = '0;
                if (rx_sync_r) state_s = IDLE;
                else           state_s = WAIT_HIGH;
            end
            default: begin
                cnt_s   = '0;
                state_s = IDLE;
            end
        endcase
    end

    // Output buffer and error pulses
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_byte_r    <= 8'h00;
            rx_valid_r   <= 1'b0;
            frame_err_r  <= 1'b0;
            parity_err_r <= 1'b0;
            overrun_r    <= 1'b0;
        end else begin
            frame_err_r  <= frame_s;
            parity_err_r <= perr_s;
            overrun_r    <= 1'b0;
            if (deliver_s && (!rx_valid_r || rxReady)) begin
                rx_byte_r  <= shift_r;
                rx_valid_r <= 1'b1;
            end else if (deliver_s) begin
                overrun_r  <= 1'b1;
            end else if (rx_valid_r && rxReady) begin
                rx_valid_r <= 1'b0;
            end else begin
                rx_valid_r <= rx_valid_r;
            end
        end
    end

    assign rxByte    = rx_byte_r;
    assign rxValid   = rx_valid_r;
    assign frameErr  = frame_err_r;
    assign parityErr = parity_err_r;
    assign overrun   = overrun_r;
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed table-driven bench for uart_rx at 10 clocks per bit.
module tb_uart_rx;
    logic       clk = 1'b0;
    logic       reset;
    logic       uartRxBit;
    logic       rxReady;
    logic [7:0] rxByte;
    logic       rxValid, frameErr, parityErr, overrun;

    int n_checks = 0;
    int n_errors = 0;
    int n_ferr = 0, n_ovr = 0, n_perr = 0, n_rise = 0;
    logic prev_valid = 1'b0;

    uart_rx #(.CLKFREQ(1_000_000), .BAUDRATE(100_000)) dut (
        .clk(clk), .reset(reset), .uartRxBit(uartRxBit), .rxReady(rxReady),
        .rxByte(rxByte), .rxValid(rxValid), .frameErr(frameErr),
        .parityErr(parityErr), .overrun(overrun)
    );

    always #5 clk = ~clk;

    // Pulse and delivery counters, sampled mid-cycle
    always @(negedge clk) begin
        if (frameErr)              n_ferr <= n_ferr + 1;
        if (overrun)               n_ovr  <= n_ovr + 1;
        if (parityErr)             n_perr <= n_perr + 1;
        if (rxValid && !prev_valid) n_rise <= n_rise + 1;
        prev_valid <= rxValid;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Drives one frame starting right after an edge (next edge is E0) and snapshots outputs
    // after edge E0+95 (v95) and E0+96 (the rest); leaves the line high when done.
    task automatic send_frame(input logic [7:0] d, input logic stop, input logic par,
                              output logic v95, output logic v96, output logic [7:0] b96,
                              output logic f96, output logic o96, output logic p96);
        uartRxBit = 1'b0;
        repeat (10) tick();
        for (int i = 0; i < 8; i++) begin
            uartRxBit = d[i];
            repeat (10) tick();
        end
`ifdef UART_RX_PARITY_EN
        uartRxBit = par;
        repeat (10) tick();
`else
        if (par) uartRxBit = 1'b1;
`endif
        uartRxBit = stop;
        repeat (6) tick();
        v95 = rxValid;
        tick();
        v96 = rxValid;
        b96 = rxByte;
        f96 = frameErr;
        o96 = overrun;
        p96 = parityErr;
        repeat (3) tick();
        uartRxBit = 1'b1;
    endtask

    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic       exp_valid;
        logic [7:0] exp_byte;
        logic       exp_ferr;
    } vec_t;

    vec_t vecs[6];
    logic v95, v96, f96, o96, p96;
    logic [7:0] b96;
    int base_ferr, base_ovr, base_rise;

    initial begin
        vecs[0] = '{8'hA5, 1'b1, 1'b1, 8'hA5, 1'b0};
        vecs[1] = '{8'h00, 1'b1, 1'b1, 8'h00, 1'b0};
        vecs[2] = '{8'hFF, 1'b1, 1'b1, 8'hFF, 1'b0};
        vecs[3] = '{8'h81, 1'b1, 1'b1, 8'h81, 1'b0};
        vecs[4] = '{8'h3C, 1'b0, 1'b0, 8'h00, 1'b1};
        vecs[5] = '{8'h5A, 1'b1, 1'b1, 8'h5A, 1'b0};

        reset = 1'b0; uartRxBit = 1'b1; rxReady = 1'b0;
        repeat (3) tick();
        check("reset_byte", {24'd0, rxByte}, 32'h00);
        check("reset_valid", {31'd0, rxValid}, 32'd0);
        check("reset_errs", {29'd0, frameErr, parityErr, overrun}, 32'd0);
        reset = 1'b1;
        repeat (5) tick();

        // Single byte, held until consumed
        send_frame(8'hA5, 1'b1, 1'b0, v95, v96, b96, f96, o96, p96);
        check("single_valid_e95", {31'd0, v95}, 32'd0);
        check("single_valid_e96", {31'd0, v96}, 32'd1);
        check("single_byte", {24'd0, b96}, 32'hA5);
        repeat (20) tick();
        check("single_hold_valid", {31'd0, rxValid}, 32'd1);
        check("single_hold_byte", {24'd0, rxByte}, 32'hA5);
        rxReady = 1'b1;
        tick();
        rxReady = 1'b0;
        check("single_consume_valid", {31'd0, rxValid}, 32'd0);
        check("single_consume_byte", {24'd0, rxByte}, 32'hA5);
        repeat (5) tick();

        // Table of independent frames
        for (int i = 0; i < 6; i++) begin
            rxReady = 1'b1; tick(); rxReady = 1'b0; tick();
            send_frame(vecs[i].data, vecs[i].stop, 1'b0, v95, v96, b96, f96, o96, p96);
            check($sformatf("vec%0d_pre_valid", i), {31'd0, v95}, 32'd0);
            check($sformatf("vec%0d_valid", i), {31'd0, v96}, {31'd0, vecs[i].exp_valid});
            if (vecs[i].exp_valid)
                check($sformatf("vec%0d_byte", i), {24'd0, b96}, {24'd0, vecs[i].exp_byte});
            check($sformatf("vec%0d_ferr", i), {31'd0, f96}, {31'd0, vecs[i].exp_ferr});
            check($sformatf("vec%0d_ovr", i), {31'd0, o96}, 32'd0);
            check($sformatf("vec%0d_perr", i), {31'd0, p96}, 32'd0);
            repeat (15) tick();
        end

        // Glitch shorter than half a bit
        rxReady = 1'b1; tick(); rxReady = 1'b0; tick();
        base_ferr = n_ferr; base_ovr = n_ovr; base_rise = n_rise;
        uartRxBit = 1'b0;
        repeat (3) tick();
        uartRxBit = 1'b1;
        repeat (30) tick();
        check("glitch_valid", {31'd0, rxValid}, 32'd0);
        check("glitch_rise", n_rise - base_rise, 32'd0);
        check("glitch_errs", (n_ferr - base_ferr) + (n_ovr - base_ovr), 32'd0);
        send_frame(8'h69, 1'b1, 1'b0, v95, v96, b96, f96, o96, p96);
        check("post_glitch_byte", {23'd0, v96, b96}, {23'd0, 1'b1, 8'h69});

        // Framing error followed by a stuck-low line
        rxReady = 1'b1; tick(); rxReady = 1'b0; tick();
        base_ferr = n_ferr; base_rise = n_rise;
        send_frame(8'h3C, 1'b0, 1'b0, v95, v96, b96, f96, o96, p96);
        uartRxBit = 1'b0;
        repeat (50) tick();
        check("ferr_pulse_at_stop", {31'd0, f96}, 32'd1);
        check("ferr_count", n_ferr - base_ferr, 32'd1);
        check("ferr_no_valid", n_rise - base_rise, 32'd0);
        uartRxBit = 1'b1;
        repeat (5) tick();
        send_frame(8'h96, 1'b1, 1'b0, v95, v96, b96, f96, o96, p96);
        check("post_ferr_byte", {23'd0, v96, b96}, {23'd0, 1'b1, 8'h96});
        check("post_ferr_count", n_ferr - base_ferr, 32'd1);

        // Overrun: back-to-back with consumer stalled
        rxReady = 1'b1; tick(); rxReady = 1'b0; tick();
        base_ovr = n_ovr;
        send_frame(8'h11, 1'b1, 1'b0, v95, v96, b96, f96, o96, p96);
        check("ovr_first_byte", {23'd0, v96, b96}, {23'd0, 1'b1, 8'h11});
        send_frame(8'h22, 1'b1, 1'b0, v95, v96, b96, f96, o96, p96);
        check("ovr_pulse", {31'd0, o96}, 32'd1);
        check("ovr_kept_byte", {23'd0, v96, b96}, {23'd0, 1'b1, 8'h11});
        check("ovr_count", n_ovr - base_ovr, 32'd1);

        // Same pair with consumer always ready
        rxReady = 1'b1;
        repeat (2) tick();
        base_ovr = n_ovr; base_rise = n_rise;
        send_frame(8'h11, 1'b1, 1'b0, v95, v96, b96, f96, o96, p96);
        check("rdy_first_byte", {23'd0, v96, b96}, {23'd0, 1'b1, 8'h11});
        send_frame(8'h22, 1'b1, 1'b0, v95, v96, b96, f96, o96, p96);
        check("rdy_second_byte", {23'd0, v96, b96}, {23'd0, 1'b1, 8'h22});
        check("rdy_no_ovr", {31'd0, o96}, 32'd0);
        check("rdy_ovr_count", n_ovr - base_ovr, 32'd0);
        check("rdy_deliveries", n_rise - base_rise, 32'd2);
        rxReady = 1'b0;
        tick();

        // Reset during data bit 4 of 0xFF with a byte already buffered
        send_frame(8'hC3, 1'b1, 1'b0, v95, v96, b96, f96, o96, p96);
        check("pre_reset_byte", {23'd0, v96, b96}, {23'd0, 1'b1, 8'hC3});
        uartRxBit = 1'b0;
        repeat (10) tick();
        uartRxBit = 1'b1;
        repeat (45) tick();
        reset = 1'b0;
        #1;
        check("midreset_byte", {24'd0, rxByte}, 32'h00);
        check("midreset_valid", {31'd0, rxValid}, 32'd0);
        check("midreset_errs", {29'd0, frameErr, parityErr, overrun}, 32'd0);
        repeat (3) tick();
        reset = 1'b1;
        base_rise = n_rise;
        repeat (60) tick();
        check("after_reset_no_delivery", n_rise - base_rise, 32'd0);
        send_frame(8'h5A, 1'b1, 1'b0, v95, v96, b96, f96, o96, p96);
        check("after_reset_byte", {23'd0, v96, b96}, {23'd0, 1'b1, 8'h5A});
        tick();
        check("after_reset_deliveries", n_rise - base_rise, 32'd1);

`ifdef UART_RX_PARITY_EN
        rxReady = 1'b1; tick(); rxReady = 1'b0; tick();
        send_frame(8'h07, 1'b1, 1'b1, v95, v96, b96, f96, o96, p96);
        check("par_good_byte", {23'd0, v96, b96}, {23'd0, 1'b1, 8'h07});
        check("par_good_perr", {31'd0, p96}, 32'd0);
        rxReady = 1'b1; tick(); rxReady = 1'b0; tick();
        send_frame(8'h07, 1'b1, 1'b0, v95, v96, b96, f96, o96, p96);
        check("par_bad_perr", {31'd0, p96}, 32'd1);
        check("par_bad_valid", {31'd0, v96}, 32'd0);
        tick();
        check("par_bad_count", n_perr, 32'd1);
`else
        check("perr_never", n_perr, 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
